// File: rtl/mux16_rr_arbiter_pkg.sv
// rtl/mux16_rr_arbiter_pkg.sv - shared types, sizes and helpers for the 16:1 mux arbiter
package mux_arb_pkg;

  localparam int N  = 16;
  localparam int SW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N-1:0] onehot(input logic [SW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// rtl/mux16_rr_arbiter_if.sv - request/grant bundle between requesters and the mux arbiter
interface mux16_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N-1:0]  req;
  logic [SW-1:0] sel;
  logic [N-1:0]  gnt;
  logic          sel_valid;
  logic          preempt;
  logic          busy;

  modport master (
    input  req,
    output sel,
    output gnt,
    output sel_valid,
    output preempt,
    output busy
  );

  modport slave (
    output req,
    input  sel,
    input  gnt,
    input  sel_valid,
    input  preempt,
    input  busy
  );

endinterface

// File: rtl/mux16_rr_arbiter_rr_pick.sv
// rtl/mux16_rr_arbiter_rr_pick.sv - round-robin next-requester pick, double-width masked priority encoder
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic [SW-1:0] pick,
  output logic          any
);

  localparam int DW = SW + 1;

  logic [N-1:0]   upto_last;
  logic [N-1:0]   above_last;
  logic [2*N-1:0] dbl;
  logic [DW-1:0]  idx;

  // Low half holds only requesters above last; the high half is the plain
  // vector, so the lowest set bit of the concatenation is the wrap-around pick.
  always_comb begin
    upto_last  = (N'(2) << last) - N'(1);
    above_last = ~upto_last;
    dbl        = {req, req & above_last};
    idx        = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) begin
        idx = DW'(i);
      end
    end
    pick = idx[SW-1:0];
    any  = |req;
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// rtl/mux16_rr_arbiter.sv - round-robin arbiter driving the select of a shared 16:1 mux
module mux16_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
)
(
  input  logic                clk,
  input  logic                rst,
  mux16_rr_arbiter_if.master  bus
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic          preempt_q, preempt_d;
  logic [SW-1:0] last_q, last_d;
  logic [HW-1:0] hold_cnt, hold_d;

  logic [SW-1:0] pick;
  logic          any_req;
  logic          others_wait;

  rr_pick u_pick (
    .req  (bus.req),
    .last (last_q),
    .pick (pick),
    .any  (any_req)
  );

  assign others_wait = |(bus.req & ~gnt_q);

  // Next-state and next-output decode; every grant end passes through IDLE.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    last_d    = last_q;
    hold_d    = hold_cnt;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          sel_d   = pick;
          gnt_d   = onehot(pick);
          valid_d = 1'b1;
          last_d  = pick;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && others_wait) begin
          state_d   = IDLE;
          gnt_d     = '0;
          valid_d   = 1'b0;
          preempt_d = 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LIM)) begin
          hold_d = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; last starts at 15 so
  // requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      last_q    <= SW'(N - 1);
      hold_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
      last_q    <= last_d;
      hold_cnt  <= hold_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.sel_valid = valid_q;
  assign bus.preempt   = preempt_q;
  assign bus.busy      = valid_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb/tb_mux16_rr_arbiter.sv - scoreboard bench for the 16:1 mux round-robin arbiter
module tb_mux16_rr_arbiter;

  typedef struct {
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        preempt;
    int          id;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   vec_id;
  exp_t exp_q[$];
  exp_t e;

  mux16_rr_arbiter_if bus ();

  mux16_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", name, id, act, want);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] rq, input logic [15:0] eg,
                      input logic [3:0] es, input logic ep);
    exp_t x;
    @(negedge clk);
    rst     = r;
    bus.req = rq;
    x.gnt     = eg;
    x.sel     = es;
    x.preempt = ep;
    x.id      = vec_id;
    vec_id++;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt", e.id, 32'(bus.gnt), 32'(e.gnt));
      chk("sel", e.id, 32'(bus.sel), 32'(e.sel));
      chk("sel_valid", e.id, 32'(bus.sel_valid), 32'(e.gnt != 16'h0));
      chk("busy", e.id, 32'(bus.busy), 32'(e.gnt != 16'h0));
      chk("preempt", e.id, 32'(bus.preempt), 32'(e.preempt));
      chk("gnt_onehot0", e.id, 32'($countones(bus.gnt) <= 1), 32'(1));
      if (bus.gnt != 16'h0) begin
        chk("gnt_at_sel", e.id, 32'(bus.gnt[bus.sel]), 32'(1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    vec_id      = 0;
    rst         = 1'b1;
    bus.req     = 16'h0;

    // reset with every requester active
    step(1, 16'hFFFF, 16'h0000, 4'd0, 0);
    step(1, 16'hFFFF, 16'h0000, 4'd0, 0);

    // single requester 5: one-cycle latency, release leaves sel in place
    step(0, 16'h0020, 16'h0020, 4'd5, 0);
    step(0, 16'h0020, 16'h0020, 4'd5, 0);
    step(0, 16'h0020, 16'h0020, 4'd5, 0);
    step(0, 16'h0000, 16'h0000, 4'd5, 0);
    step(0, 16'h0000, 16'h0000, 4'd5, 0);

    // fairness: 0 and 4 alternate, 8 grant cycles then a preempt gap
    for (int i = 0; i < 8; i++) step(0, 16'h0011, 16'h0001, 4'd0, 0);
    step(0, 16'h0011, 16'h0000, 4'd0, 1);
    for (int i = 0; i < 8; i++) step(0, 16'h0011, 16'h0010, 4'd4, 0);
    step(0, 16'h0011, 16'h0000, 4'd4, 1);
    step(0, 16'h0011, 16'h0001, 4'd0, 0);
    step(0, 16'h0000, 16'h0000, 4'd0, 0);

    // wrap: grant 14, then 15 beats 0, handoff to 0 keeps the gap cycle
    step(0, 16'h4000, 16'h4000, 4'd14, 0);
    step(0, 16'h0000, 16'h0000, 4'd14, 0);
    step(0, 16'h8001, 16'h8000, 4'd15, 0);
    step(0, 16'h0001, 16'h0000, 4'd15, 0);
    step(0, 16'h0001, 16'h0001, 4'd0, 0);
    step(0, 16'h0000, 16'h0000, 4'd0, 0);

    // lone holder: never preempted, counter saturates
    for (int i = 0; i < 20; i++) step(0, 16'h0008, 16'h0008, 4'd3, 0);
    @(posedge clk);
    #2;
    chk("hold_cnt_sat", vec_id, 32'(dut.hold_cnt), 32'd8);
    step(0, 16'h0000, 16'h0000, 4'd3, 0);

    // reset during a grant on 9, then last=15 favours requester 0
    step(0, 16'h0200, 16'h0200, 4'd9, 0);
    step(0, 16'h0200, 16'h0200, 4'd9, 0);
    step(1, 16'h0200, 16'h0000, 4'd0, 0);
    step(0, 16'h0201, 16'h0001, 4'd0, 0);
    step(0, 16'h0201, 16'h0001, 4'd0, 0);
    step(0, 16'h0000, 16'h0000, 4'd0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", vec_id, 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
